// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine for the execute stage; busyE stalls the pipeline
// while an operation runs and doneE pulses for one cycle with the {HI,LO} result.
module muldiv_unit #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        cancelE,
    output logic        busyE,
    output logic        doneE,
    output logic [31:0] hiE,
    output logic [31:0] loE,
    output logic [1:0]  stateE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  count;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] dvs_q;
    logic [63:0] rq;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        accept;
    logic        in_signed_div;
    logic [31:0] mag_a_in;
    logic [31:0] mag_b_in;
    logic        is_div;
    logic        is_signed;
    logic        div_zero;
    logic [63:0] shifted;
    logic [32:0] diff;
    logic [63:0] rq_step;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [63:0] result;

    assign accept        = (state == IDLE) & startE & ~cancelE;
    assign in_signed_div = (opE == 2'b10);
    assign mag_a_in      = (in_signed_div & srcaE[31]) ? -srcaE : srcaE;
    assign mag_b_in      = (in_signed_div & srcbE[31]) ? -srcbE : srcbE;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign div_zero  = is_div & (b_q == 32'd0);

    // One restoring step: shift {rem,quot} left, keep the trial subtraction if it did not borrow.
    assign shifted = {rq[62:0], 1'b0};
    assign diff    = {1'b0, shifted[63:32]} - {1'b0, dvs_q};
    assign rq_step = diff[32] ? shifted : {diff[31:0], shifted[31:1], 1'b1};

    assign quot = (is_signed & (a_q[31] ^ b_q[31])) ? -rq_step[31:0] : rq_step[31:0];
    assign rem  = (is_signed & a_q[31]) ? -rq_step[63:32] : rq_step[63:32];

    assign ext_a   = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign ext_b   = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign product = ext_a * ext_b;

    always_comb begin
        result = product;
        if (is_div) begin
            if (div_zero) result = {a_q, 32'hFFFF_FFFF};
            else          result = {rem, quot};
        end
    end

    always_comb begin
        state_next = state;
        busyE      = 1'b0;
        doneE      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                    busyE      = 1'b1;
                end
            end
            BUSY: begin
                busyE = 1'b1;
                if (cancelE)            state_next = IDLE;
                else if (count == 6'd0) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
                doneE      = ~cancelE;
            end
            default: state_next = IDLE;
        endcase
        if (!resetn) busyE = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= 6'd0;
            op_q  <= 2'b00;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            dvs_q <= 32'd0;
            rq    <= 64'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else if (accept) begin
            op_q  <= opE;
            a_q   <= srcaE;
            b_q   <= srcbE;
            dvs_q <= mag_b_in;
            rq    <= {32'd0, mag_a_in};
            if (!opE[1])               count <= 6'(MUL_CYCLES - 1);
            else if (srcbE == 32'd0)   count <= 6'd0;
            else                       count <= 6'd31;
        end else if ((state == BUSY) && !cancelE) begin
            rq <= rq_step;
            if (count != 6'd0) begin
                count <= count - 6'd1;
            end else begin
                hi_q <= result[63:32];
                lo_q <= result[31:0];
            end
        end
    end

    assign hiE    = hi_q;
    assign loE    = lo_q;
    assign stateE = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: scenario tasks drive operations, a result queue is filled at start
// and drained on doneE, and busy/done timing is checked against the expected latency.
module tb_muldiv_unit;

    localparam int MUL_CYCLES = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        startE;
    logic [1:0]  opE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        cancelE;
    logic        busyE;
    logic        doneE;
    logic [31:0] hiE;
    logic [31:0] loE;
    logic [1:0]  stateE;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    muldiv_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .resetn(resetn), .startE(startE), .opE(opE),
        .srcaE(srcaE), .srcbE(srcbE), .cancelE(cancelE),
        .busyE(busyE), .doneE(doneE), .hiE(hiE), .loE(loE), .stateE(stateE)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (op == 2'b00) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        if (op == 2'b01) return {32'd0, a} * {32'd0, b};
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b11) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [31:0] b);
        if (!op[1]) return MUL_CYCLES;
        if (b == 32'd0) return 1;
        return 32;
    endfunction

    // Starts one op and holds startE high through DONE; returns right after the DONE sample.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
        int lat;
        int busy_cnt;
        int done_cyc;
        logic [63:0] exp;
        lat = latency(op, b);
        @(posedge clk); #1;
        startE = 1'b1; opE = op; srcaE = a; srcbE = b;
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        checks++;
        if (busyE !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_cycle0: got %b expected 1", name, busyE);
        end
        busy_cnt = 1;
        done_cyc = 0;
        for (int c = 1; c <= lat + 4 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (doneE === 1'b1) done_cyc = c;
            else if (busyE === 1'b1) busy_cnt++;
        end
        checks++;
        if (done_cyc != lat + 1) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, lat + 1);
        end
        checks++;
        if (busy_cnt != lat + 1) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, lat + 1);
        end
        exp = exp_q.pop_front();
        if (done_cyc != 0) begin
            checks++;
            if (busyE !== 1'b0) begin
                failures++;
                $display("FAIL %s busy_in_done: got %b expected 0", name, busyE);
            end
            checks++;
            if ({hiE, loE} !== exp) begin
                failures++;
                $display("FAIL %s result: got %h_%h expected %h_%h", name, hiE, loE, exp[63:32], exp[31:0]);
            end
            last_hi = exp[63:32];
            last_lo = exp[31:0];
        end
    endtask

    task automatic idle_check(input string name);
        @(posedge clk); #1;
        startE = 1'b0;
        @(negedge clk);
        checks++;
        if (busyE !== 1'b0 || doneE !== 1'b0 || hiE !== last_hi || loE !== last_lo) begin
            failures++;
            $display("FAIL %s idle: got busy=%b done=%b hi=%h lo=%h expected busy=0 done=0 hi=%h lo=%h",
                     name, busyE, doneE, hiE, loE, last_hi, last_lo);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; startE = 1'b1; opE = 2'b10; srcaE = 32'd9; srcbE = 32'd1; cancelE = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busyE !== 1'b0 || doneE !== 1'b0 || hiE !== 32'd0 || loE !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b hi=%h lo=%h expected all 0", busyE, doneE, hiE, loE);
        end
        @(posedge clk); #1;
        startE = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (busyE !== 1'b0 || doneE !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got busy=%b done=%b expected 0 0", busyE, doneE);
        end
    endtask

    task automatic test_multiply();
        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, "mult_neg");
        idle_check("mult_neg");
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, "multu_max");
        idle_check("multu_max");
    endtask

    task automatic test_divide();
        run_op(2'b11, 32'd100, 32'd7, "divu_100_7");
        idle_check("divu_100_7");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
        idle_check("div_neg7_2");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        idle_check("div_overflow");
    endtask

    task automatic test_div_zero();
        run_op(2'b11, 32'd5, 32'd0, "divu_zero");
        run_op(2'b00, 32'd3, 32'd4, "after_zero");
        idle_check("after_zero");
        run_op(2'b10, 32'hFFFF_FF00, 32'd0, "div_zero_signed");
        idle_check("div_zero_signed");
    endtask

    task automatic test_back_to_back();
        run_op(2'b10, 32'd1000, 32'hFFFF_FFFD, "b2b_div");
        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, "b2b_multu");
        run_op(2'b11, 32'hDEAD_BEEF, 32'd16, "b2b_divu");
        idle_check("b2b");
    endtask

    task automatic test_start_cancel();
        int seen;
        @(posedge clk); #1;
        startE = 1'b1; cancelE = 1'b1; opE = 2'b11; srcaE = 32'd9; srcbE = 32'd3;
        @(negedge clk);
        checks++;
        if (busyE !== 1'b0) begin
            failures++;
            $display("FAIL start_cancel_busy: got %b expected 0", busyE);
        end
        @(posedge clk); #1;
        startE = 1'b0; cancelE = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (busyE !== 1'b0 || doneE !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL start_cancel_quiet: got %0d active cycles expected 0", seen);
        end
    endtask

    task automatic test_cancel();
        int dones;
        @(posedge clk); #1;
        startE = 1'b1; opE = 2'b10; srcaE = 32'd1000; srcbE = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
        end
        cancelE = 1'b1;
        @(negedge clk);
        checks++;
        if (busyE !== 1'b1) begin
            failures++;
            $display("FAIL cancel_cycle10_busy: got %b expected 1", busyE);
        end
        @(posedge clk); #1;
        cancelE = 1'b0; startE = 1'b0;
        @(negedge clk);
        checks++;
        if (busyE !== 1'b0) begin
            failures++;
            $display("FAIL cancel_cycle11_busy: got %b expected 0", busyE);
        end
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (doneE !== 1'b0 || busyE !== 1'b0) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL cancel_no_done: got %0d active cycles expected 0", dones);
        end
        checks++;
        if (hiE !== last_hi || loE !== last_lo) begin
            failures++;
            $display("FAIL cancel_hold: got %h_%h expected %h_%h", hiE, loE, last_hi, last_lo);
        end
    endtask

    task automatic test_reset_abort();
        @(posedge clk); #1;
        startE = 1'b1; opE = 2'b10; srcaE = 32'd1000; srcbE = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (busyE !== 1'b0 || doneE !== 1'b0 || hiE !== 32'd0 || loE !== 32'd0) begin
            failures++;
            $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h expected all 0", busyE, doneE, hiE, loE);
        end
        startE = 1'b0;
        last_hi = 32'd0;
        last_lo = 32'd0;
        @(posedge clk); #1;
        resetn = 1'b1;
        idle_check("reset_abort");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "after_reset_div");
        idle_check("after_reset_div");
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 10; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(op, a, b, "random");
        end
        idle_check("random");
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_zero();
        test_back_to_back();
        test_start_cancel();
        test_cancel();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide engine in the execute stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU operands from E, runs a fixed-latency multiply or a 32-iteration restoring divide, and returns a 64-bit {HI,LO} result to the HI/LO writeback path. Its `busyE` output is the `isMulOrDivComputingE` input of the hazard unit. That input stalls F through W without flushing E while the operation runs.

## Interface
- `MUL_CYCLES`, default 2: extra busy cycles for multiply, legal range 1–8.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `resetn` in 1: asynchronous active-low reset.
- `startE` in 1: E holds a mul/div instruction with valid, forwarded operands.
- `opE` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srcaE` in 32: rs operand (multiplicand or dividend).
- `srcbE` in 32: rt operand (multiplier or divisor).
- `cancelE` in 1: abort the in-flight operation (exception/flush); no result is produced.
- `busyE` out 1: operation in progress; drives hazard `isMulOrDivComputingE`.
- `doneE` out 1: one-cycle pulse; `hiE`/`loE` are valid this cycle.
- `hiE` out 32: product[63:32] or remainder.
- `loE` out 32: product[31:0] or quotient.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - If `startE & ~cancelE`: capture the operands and op, load the iteration counter, and go to BUSY.
  - `busyE` is asserted combinationally in this same cycle.
- BUSY:
  - Counter decrements each cycle.
  - At count 0, go to DONE.
  - `busyE = 1`.
- DONE:
  - `doneE = 1`, `busyE = 0`, `hiE`/`loE` valid.
  - `startE` is ignored here: E still holds the finished instruction, so it must not restart.
  - Always returns to IDLE.
- `busyE = (IDLE & startE & ~cancelE) | BUSY`. It is never asserted in DONE.
- `cancelE` in any state: go to IDLE next edge, no `doneE`, and `hiE`/`loE` keep their previous values.
- Multiply:
  - MULT sign-extends both operands to 64 bits; MULTU zero-extends.
  - Product is registered into the result at the end of the last BUSY cycle.
  - Internal pipelining of the product is allowed if latency is unchanged.
- Divide:
  - Unsigned radix-2 restoring divide on the magnitudes: 32 iterations, one quotient bit per BUSY cycle, 64-bit remainder/quotient shift register.
  - DIV sign fix-up is applied when entering DONE:
    - quotient is negated if the operand signs differ;
    - remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO = 0x80000000, HI = 0.
- Divide by zero (`srcbE == 0`, DIV or DIVU):
  - No iterations; BUSY lasts one cycle.
  - Result is LO = 0xFFFFFFFF, HI = `srcaE`.
- `hiE`/`loE` hold the last completed result until the next DONE. Reset value is 0.
- Reset values:
  - state IDLE;
  - `busyE` 0 (forced combinationally while `resetn` is low);
  - `doneE` 0;
  - `hiE`/`loE` 0;
  - counter 0.
- Reset mid-operation abandons it silently.

## Timing
- Cycle 0 is the cycle `startE` is seen in IDLE. L = `MUL_CYCLES` for multiply, 32 for divide, 1 for divide by zero.
- `busyE` is high in cycles 0..L, so the pipeline is stalled for L+1 cycles.
- DONE is cycle L+1: `doneE` = 1 and the result is valid. The pipeline advances at the end of that cycle.
- Next earliest accepted start is cycle L+2, when the following instruction is in E.
- Back-to-back mul/div instructions therefore have a 1-cycle gap with `busyE` low.
- DIV/DIVU with the default parameter: 33 busy cycles. MULT/MULTU: 3 busy cycles.
- `cancelE` sampled at the edge ending cycle k (k ≤ L): `busyE` = 0 from cycle k+1.
- If `startE` and `cancelE` are high together in IDLE: no start, and `busyE` = 0 that cycle.

## Test plan
- MULT 7 × 0xFFFFFFFD: `busyE` high cycles 0–2; cycle 3 `doneE` = 1, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 2: HI = 0x00000001, LO = 0xFFFFFFFE.
- DIVU 100 / 7:
  - `busyE` high cycles 0–32;
  - `doneE` in cycle 33;
  - LO = 14, HI = 2.
- DIV signed cases:
  - 0xFFFFFFF9 / 2 gives LO = 0xFFFFFFFD, HI = 0xFFFFFFFF;
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- DIVU 5 / 0:
  - `busyE` high cycles 0–1;
  - cycle 2 `doneE`, LO = 0xFFFFFFFF, HI = 5.
  - Then `startE` held high through DONE: no restart; next start is accepted only in cycle 3.
- Abort cases:
  - DIV started, `cancelE` pulsed in cycle 10: `busyE` 0 from cycle 11, `doneE` never pulses, HI/LO keep the prior result.
  - Same with `resetn` pulled low in cycle 10 instead: outputs go to 0 asynchronously.
